// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl
// Host-to-keyboard LED command sequencer. Sends the two-byte command ED,
// {00000, mask} over the open-drain PS/2 lines. After each byte it waits for
// the device FA acknowledge. A byte that fails is resent, up to MAX_RETRIES
// extra times.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   led_mask, led_req   LED bits (0 scroll, 1 num, 2 caps) and one-cycle request
//   busy, done, error   command in flight / both bytes acked / retries exhausted
//   ps2_clk_i/data_i    raw line levels (asynchronous)
//   ps2_*_drive_low     1 pulls the corresponding line low, 0 releases it
//   rx_byte, rx_valid   decoded bytes from the PS/2 receive block
//   rx_gate             tells the receive block to ignore line activity
module ps2_led_ctrl #(
  parameter int INHIBIT_CYC     = 5000,
  parameter int BIT_TIMEOUT_CYC = 100000,
  parameter int ACK_TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRIES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] led_mask,
  input  logic       led_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_gate
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_LINE_ACK,
    S_WAIT_RESP
  } state_t;

  localparam logic [31:0] INH_LAST  = 32'(INHIBIT_CYC - 1);
  localparam logic [31:0] INH_DATA  = 32'(INHIBIT_CYC - 2);
  localparam logic [31:0] BIT_LAST  = 32'(BIT_TIMEOUT_CYC - 1);
  localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  state_t      r_state;
  logic [1:0]  r_clkSync;
  logic [1:0]  r_dataSync;
  logic        r_clkPrev;
  logic [31:0] r_cnt;
  logic [3:0]  r_bitCnt;
  logic [7:0]  r_txByte;
  logic [7:0]  r_retry;
  logic        r_byteIdx;
  logic [2:0]  r_mask;
  logic        r_pendValid;
  logic [2:0]  r_pendMask;

  logic w_clkFall;
  logic w_bitTimeout;
  logic w_ackTimeout;
  logic w_fail;

  // Decide whether the current attempt has failed this cycle. A falling
  // edge beats a bit timeout. A received byte beats an ACK timeout. The
  // comparisons use >= because an ignored byte can let the counter step
  // past the limit.
  always_comb begin
    w_clkFall    = r_clkPrev & ~r_clkSync[1];
    w_bitTimeout = (r_cnt >= BIT_LAST);
    w_ackTimeout = (r_cnt >= ACK_LAST);
    w_fail       = 1'b0;
    case (r_state)
      S_BITS:      w_fail = ~w_clkFall & w_bitTimeout;
      S_LINE_ACK:  w_fail = w_clkFall ? r_dataSync[1] : w_bitTimeout;
      S_WAIT_RESP: w_fail = rx_valid ? (rx_byte == 8'hFE) : w_ackTimeout;
      default:     w_fail = 1'b0;
    endcase
  end

  // Line synchronizers, the command FSM and all registered outputs.
  // A failed attempt is handled ahead of the per-state logic.
  // The INHIBIT state pulls data low one cycle before it releases the
  // clock, so the device sees the request-to-send start condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_clkSync          <= 2'b00;
      r_dataSync         <= 2'b00;
      r_clkPrev          <= 1'b0;
      r_cnt              <= 32'd0;
      r_bitCnt           <= 4'd0;
      r_txByte           <= 8'd0;
      r_retry            <= 8'd0;
      r_byteIdx          <= 1'b0;
      r_mask             <= 3'd0;
      r_pendValid        <= 1'b0;
      r_pendMask         <= 3'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      rx_gate            <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_i};
      r_dataSync <= {r_dataSync[0], ps2_data_i};
      r_clkPrev  <= r_clkSync[1];
      done       <= 1'b0;
      error      <= 1'b0;

      if (led_req && r_state != S_IDLE) begin
        r_pendValid <= 1'b1;
        r_pendMask  <= led_mask;
      end

      if (w_fail) begin
        if (r_retry < RETRY_MAX) begin
          r_retry            <= r_retry + 8'd1;
          r_state            <= S_INHIBIT;
          r_cnt              <= 32'd0;
          ps2_clk_drive_low  <= 1'b1;
          ps2_data_drive_low <= 1'b0;
          rx_gate            <= 1'b1;
        end else begin
          error              <= 1'b1;
          r_state            <= S_IDLE;
          busy               <= 1'b0;
          ps2_clk_drive_low  <= 1'b0;
          ps2_data_drive_low <= 1'b0;
          rx_gate            <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            // A new request wins over the pending slot; both carry the newest mask.
            if (led_req || r_pendValid) begin
              r_mask             <= led_req ? led_mask : r_pendMask;
              r_pendValid        <= 1'b0;
              r_byteIdx          <= 1'b0;
              r_txByte           <= 8'hED;
              r_retry            <= 8'd0;
              r_cnt              <= 32'd0;
              r_state            <= S_INHIBIT;
              busy               <= 1'b1;
              ps2_clk_drive_low  <= 1'b1;
              ps2_data_drive_low <= 1'b0;
              rx_gate            <= 1'b1;
            end
          end

          S_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
              r_state            <= S_START;
              r_cnt              <= 32'd0;
              ps2_clk_drive_low  <= 1'b0;
              ps2_data_drive_low <= 1'b1;
            end else begin
              if (r_cnt == INH_DATA) begin
                ps2_data_drive_low <= 1'b1;
              end
              r_cnt <= r_cnt + 32'd1;
            end
          end

          S_START: begin
            r_bitCnt <= 4'd0;
            r_cnt    <= 32'd0;
            r_state  <= S_BITS;
          end

          S_BITS: begin
            // r_bitCnt counts the edges already seen: 0-7 data (LSB first),
            // 8 odd parity, 9 stop.
            if (w_clkFall) begin
              r_cnt    <= 32'd0;
              r_bitCnt <= r_bitCnt + 4'd1;
              if (r_bitCnt < 4'd8) begin
                ps2_data_drive_low <= ~r_txByte[r_bitCnt[2:0]];
              end else if (r_bitCnt == 4'd8) begin
                ps2_data_drive_low <= ^r_txByte;
              end else begin
                ps2_data_drive_low <= 1'b0;
                r_state            <= S_LINE_ACK;
              end
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          S_LINE_ACK: begin
            // The no-ack case is caught by w_fail, so a falling edge here
            // means the device pulled data low.
            if (w_clkFall) begin
              r_state <= S_WAIT_RESP;
              r_cnt   <= 32'd0;
              rx_gate <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          S_WAIT_RESP: begin
            if (rx_valid && rx_byte == 8'hFA) begin
              if (!r_byteIdx) begin
                r_txByte          <= {5'b00000, r_mask};
                r_byteIdx         <= 1'b1;
                r_retry           <= 8'd0;
                r_cnt             <= 32'd0;
                r_state           <= S_INHIBIT;
                ps2_clk_drive_low <= 1'b1;
                rx_gate           <= 1'b1;
              end else begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          default: begin
            r_state            <= S_IDLE;
            busy               <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            rx_gate            <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// tb_ps2_led_ctrl
// Directed bench for ps2_led_ctrl. A small PS/2 device model does the following:
// - waits for the host to release the clock,
// - clocks out 11 pulses and captures the start, data, parity and stop bits,
// - optionally pulls data low for the line-ack.
// Responses (FA/FE/others) are injected on rx_byte/rx_valid directly.
module tb_ps2_led_ctrl;

  localparam int INH   = 20;
  localparam int BITTO = 1000;
  localparam int ACKTO = 200;
  localparam int RETR  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] led_mask;
  logic       led_req;
  logic       busy, done, error;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_gate;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;

  int total = 0;
  int bad   = 0;

  // Open-drain lines: either side can pull low.
  assign ps2_clk_i  = devClk & ~ps2_clk_drive_low;
  assign ps2_data_i = devData & ~ps2_data_drive_low;

  always #5 clk = ~clk;

  ps2_led_ctrl #(
    .INHIBIT_CYC(INH),
    .BIT_TIMEOUT_CYC(BITTO),
    .ACK_TIMEOUT_CYC(ACKTO),
    .MAX_RETRIES(RETR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .led_mask(led_mask),
    .led_req(led_req),
    .busy(busy),
    .done(done),
    .error(error),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_gate(rx_gate)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request, driven on a negedge
  task automatic applyStimulus(input logic [2:0] m);
    @(negedge clk);
    led_mask = m;
    led_req  = 1'b1;
    @(negedge clk);
    led_req  = 1'b0;
  endtask

  // One-cycle receive strobe; returns on the negedge where done/error are visible
  task automatic sendRx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // Device side of one host-to-device frame. frm[0]=start, [8:1]=byte,
  // [9]=parity, [10]=stop; inh = cycles the clock line was held low.
  task automatic deviceFrame(input logic ackLow, output logic [10:0] frm, output int inh);
    int n;
    frm = '1;
    inh = 0;
    n   = 0;
    while (!ps2_clk_drive_low && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ps2_clk_drive_low) begin
      checkOutput("inhibit_start", 32'(ps2_clk_drive_low), 32'd1);
      return;
    end
    n = 0;
    while (ps2_clk_drive_low && n < 6000) begin
      inh++;
      @(negedge clk);
      n++;
    end
    if (ps2_clk_drive_low) begin
      checkOutput("inhibit_end", 32'(ps2_clk_drive_low), 32'd0);
      return;
    end
    frm[0] = ps2_data_i;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ackLow) devData = 1'b0;
      repeat (4) @(negedge clk);
      devClk = 1'b0;
      repeat (8) @(negedge clk);
      if (k <= 10) frm[k] = ps2_data_i;
      devClk = 1'b1;
    end
    repeat (2) @(negedge clk);
    devData = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input logic [10:0] frm,
                            input logic [7:0] expByte, input logic expPar);
    checkOutput({tag, "_start"},  32'(frm[0]),   32'd0);
    checkOutput({tag, "_byte"},   32'(frm[8:1]), 32'(expByte));
    checkOutput({tag, "_parity"}, 32'(frm[9]),   32'(expPar));
    checkOutput({tag, "_stop"},   32'(frm[10]),  32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},    32'(busy),               32'd0);
    checkOutput({tag, "_clkdrv"},  32'(ps2_clk_drive_low),  32'd0);
    checkOutput({tag, "_datadrv"}, 32'(ps2_data_drive_low), 32'd0);
    checkOutput({tag, "_rxgate"},  32'(rx_gate),            32'd0);
    checkOutput({tag, "_done"},    32'(done),               32'd0);
    checkOutput({tag, "_error"},   32'(error),              32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [10:0] frm;
    int          inh;
    int          errCnt;
    int          clkLowCnt;
    int          n;

    rst_n    = 1'b0;
    led_req  = 1'b0;
    led_mask = 3'd0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal update, mask 101
    applyStimulus(3'b101);
    checkOutput("accept_busy",   32'(busy),              32'd1);
    checkOutput("accept_clkdrv", 32'(ps2_clk_drive_low), 32'd1);
    deviceFrame(1'b1, frm, inh);
    checkOutput("inhibit_len", 32'(inh), 32'd20);
    checkFrame("n_b0", frm, 8'hED, 1'b1);
    checkOutput("wait_rxgate", 32'(rx_gate), 32'd0);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("n_b1", frm, 8'h05, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("n_done",  32'(done),  32'd1);
    checkOutput("n_error", 32'(error), 32'd0);
    @(negedge clk);
    checkOutput("n_done_pulse", 32'(done), 32'd0);
    checkOutput("n_busy_end",   32'(busy), 32'd0);

    // Resend request: FE after first byte
    applyStimulus(3'b011);
    deviceFrame(1'b1, frm, inh);
    checkFrame("r_b0a", frm, 8'hED, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFE);
    deviceFrame(1'b1, frm, inh);
    checkFrame("r_b0b", frm, 8'hED, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("r_b1", frm, 8'h03, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("r_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);

    // Retry exhaustion: no response at all
    applyStimulus(3'b111);
    for (int i = 0; i < 3; i++) begin
      deviceFrame(1'b1, frm, inh);
      checkFrame("x_b0", frm, 8'hED, 1'b1);
    end
    errCnt    = 0;
    clkLowCnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (error) errCnt++;
      if (ps2_clk_drive_low) clkLowCnt++;
    end
    checkOutput("x_error_pulses", 32'(errCnt),    32'd1);
    checkOutput("x_no_4th_frame", 32'(clkLowCnt), 32'd0);
    checkOutput("x_busy",         32'(busy),      32'd0);

    // Missing line-ack, then unrelated byte ignored
    applyStimulus(3'b010);
    deviceFrame(1'b0, frm, inh);
    checkFrame("m_b0a", frm, 8'hED, 1'b1);
    checkOutput("m_retry_clkdrv", 32'(ps2_clk_drive_low), 32'd1);
    checkOutput("m_retry_rxgate", 32'(rx_gate),           32'd1);
    deviceFrame(1'b1, frm, inh);
    checkFrame("m_b0b", frm, 8'hED, 1'b1);
    repeat (3) @(negedge clk);
    sendRx(8'h1C);
    repeat (3) @(negedge clk);
    checkOutput("m_ignore_busy",   32'(busy),              32'd1);
    checkOutput("m_ignore_clkdrv", 32'(ps2_clk_drive_low), 32'd0);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("m_b1", frm, 8'h02, 1'b0);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("m_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);

    // Pending request: masks 2 then 4 while busy, latest wins
    applyStimulus(3'b001);
    applyStimulus(3'b010);
    applyStimulus(3'b100);
    deviceFrame(1'b1, frm, inh);
    checkFrame("p1_b0", frm, 8'hED, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("p1_b1", frm, 8'h01, 1'b0);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("p1_done", 32'(done), 32'd1);
    deviceFrame(1'b1, frm, inh);
    checkFrame("p2_b0", frm, 8'hED, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("p2_b1", frm, 8'h04, 1'b0);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("p2_done", 32'(done), 32'd1);
    clkLowCnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2_clk_drive_low || busy) clkLowCnt++;
    end
    checkOutput("p_no_third", 32'(clkLowCnt), 32'd0);

    // Reset in the middle of BITS
    applyStimulus(3'b111);
    n = 0;
    while (ps2_clk_drive_low && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_released", 32'(ps2_clk_drive_low), 32'd0);
    for (int k = 0; k < 2; k++) begin
      repeat (4) @(negedge clk);
      devClk = 1'b0;
      repeat (8) @(negedge clk);
      devClk = 1'b1;
    end
    checkOutput("rst_mid_datadrv", 32'(ps2_data_drive_low), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("rst_mid");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(3'b110);
    deviceFrame(1'b1, frm, inh);
    checkFrame("a_b0", frm, 8'hED, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    deviceFrame(1'b1, frm, inh);
    checkFrame("a_b1", frm, 8'h06, 1'b1);
    repeat (5) @(negedge clk);
    sendRx(8'hFA);
    checkOutput("a_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
